// File: rtl/secuenciador_billetes_pkg.sv
// Shared types and constants for the cash-dispense sequencer: FSM state encoding,
// error codes and default cassette denominations.
package secuenciador_billetes_pkg;

  localparam int NUM_CAS = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAN     = 3'd1,
    ST_DISP     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } estado_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STOCK = 2'b01;
  localparam logic [1:0] ERR_TOUT  = 2'b10;
  localparam logic [1:0] ERR_ZERO  = 2'b11;

  // Cassette 0 holds the largest bill; values must be strictly decreasing.
  localparam int DEN0_DEF        = 20000;
  localparam int DEN1_DEF        = 10000;
  localparam int DEN2_DEF        = 5000;
  localparam int DEN3_DEF        = 1000;
  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/secuenciador_billetes_if.sv
// Bundle of the ATM-side command/status signals and the dispenser req/ack pair.
// slave = the sequencer, master = ATM controller plus dispenser.
interface secuenciador_billetes_if
  import secuenciador_billetes_pkg::*;
#(
  parameter int MONTO_W = 32,
  parameter int CNT_W   = 10
);
  logic                   entregar_dinero;
  logic [MONTO_W-1:0]     monto;
  logic                   carga_stb;
  logic [1:0]             carga_sel;
  logic [CNT_W-1:0]       carga_cnt;
  // Dispenser handshake: billete_req acts as valid and stays high with billete_sel
  // stable until the cycle billete_ack (ready) is seen; one bill moves on that edge,
  // and req is low for at least one cycle before the next bill is requested.
  logic                   billete_req;
  logic [1:0]             billete_sel;
  logic                   billete_ack;
  logic                   ocupado;
  logic                   dispensa_ok;
  logic                   dispensa_error;
  logic [1:0]             error_cod;
  logic [MONTO_W-1:0]     restante;
  logic [4*CNT_W-1:0]     conteo;
  estado_t                estado;

  modport slave (
    input  entregar_dinero, monto, carga_stb, carga_sel, carga_cnt, billete_ack,
    output billete_req, billete_sel, ocupado, dispensa_ok, dispensa_error,
           error_cod, restante, conteo, estado
  );

  modport master (
    output entregar_dinero, monto, carga_stb, carga_sel, carga_cnt, billete_ack,
    input  billete_req, billete_sel, ocupado, dispensa_ok, dispensa_error,
           error_cod, restante, conteo, estado
  );
endinterface

// File: rtl/secuenciador_billetes_planificador.sv
// One greedy planning step: picks the largest denomination that still fits the
// remaining amount and has shadow stock. Purely combinational.
module secuenciador_billetes_planificador #(
  parameter int                       MONTO_W = 32,
  parameter int                       CNT_W   = 10,
  parameter logic [3:0][MONTO_W-1:0]  DEN_TAB = '0
) (
  input  logic [MONTO_W-1:0]         rem_i,
  input  logic [3:0][CNT_W-1:0]      shadow_i,
  output logic [1:0]                 idx_o,
  output logic                       found_o
);

  // Scan from smallest to largest so the largest fitting bill is the last to win.
  always_comb begin
    idx_o   = 2'd0;
    found_o = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if ((DEN_TAB[i] <= rem_i) && (shadow_i[i] != '0)) begin
        idx_o   = 2'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secuenciador_billetes.sv
// Cash-dispense sequencer: plans the bill breakdown against a shadow stock, then
// drives the dispenser one bill at a time. Optional macro ACK_TIMEOUT_EN adds an ack timeout.
module secuenciador_billetes
  import secuenciador_billetes_pkg::*;
#(
  parameter int MONTO_W = 32,
  parameter int CNT_W   = 10,
  parameter int DEN0    = DEN0_DEF,
  parameter int DEN1    = DEN1_DEF,
  parameter int DEN2    = DEN2_DEF,
  parameter int DEN3    = DEN3_DEF
`ifdef ACK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  secuenciador_billetes_if.slave   bus
);

  localparam logic [3:0][MONTO_W-1:0] DEN_TAB =
    {MONTO_W'(DEN3), MONTO_W'(DEN2), MONTO_W'(DEN1), MONTO_W'(DEN0)};

  estado_t                 state_q, state_d;
  logic [MONTO_W-1:0]      rem_q, rem_d;
  logic [MONTO_W-1:0]      restante_q, restante_d;
  logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0][CNT_W-1:0]   shadow_q, shadow_d;
  logic [3:0][CNT_W-1:0]   n_q, n_d;
  logic [1:0]              sel_q, sel_d;
  logic                    req_q, req_d;
  logic [1:0]              error_cod_q, error_cod_d;

`ifdef ACK_TIMEOUT_EN
  localparam int TOUT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TOUT_W-1:0]       tout_q, tout_d;
`endif

  logic [1:0]              plan_idx;
  logic                    plan_found;
  logic [MONTO_W-1:0]      plan_rem;
  logic [1:0]              disp_idx;
  logic                    disp_any;

  secuenciador_billetes_planificador #(
    .MONTO_W (MONTO_W),
    .CNT_W   (CNT_W),
    .DEN_TAB (DEN_TAB)
  ) u_plan (
    .rem_i    (rem_q),
    .shadow_i (shadow_q),
    .idx_o    (plan_idx),
    .found_o  (plan_found)
  );

  assign plan_rem = rem_q - DEN_TAB[plan_idx];

  // Bills are delivered starting from the largest denomination still planned.
  always_comb begin
    disp_idx = 2'd0;
    disp_any = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (n_q[i] != '0) begin
        disp_idx = 2'(i);
        disp_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    restante_d  = restante_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    n_d         = n_q;
    sel_d       = sel_q;
    req_d       = req_q;
    error_cod_d = error_cod_q;
`ifdef ACK_TIMEOUT_EN
    tout_d      = tout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Reload lands before the shadow copy so a same-cycle start plans with it.
        if (bus.carga_stb) cnt_d[bus.carga_sel] = bus.carga_cnt;
        if (bus.entregar_dinero) begin
          restante_d = bus.monto;
          rem_d      = bus.monto;
          shadow_d   = cnt_d;
          n_d        = '0;
          if (bus.monto == '0) begin
            error_cod_d = ERR_ZERO;
            state_d     = ST_ERR;
          end else begin
            error_cod_d = ERR_NONE;
            state_d     = ST_PLAN;
          end
        end
      end
      ST_PLAN: begin
        if (rem_q == '0) begin
          state_d = ST_DISP;
        end else if (plan_found) begin
          rem_d              = plan_rem;
          shadow_d[plan_idx] = shadow_q[plan_idx] - CNT_W'(1);
          n_d[plan_idx]      = n_q[plan_idx] + CNT_W'(1);
          if (plan_rem == '0) state_d = ST_DISP;
        end else begin
          error_cod_d = ERR_STOCK;
          state_d     = ST_ERR;
        end
      end
      ST_DISP: begin
        if (disp_any) begin
          req_d   = 1'b1;
          sel_d   = disp_idx;
          state_d = ST_WAIT_ACK;
`ifdef ACK_TIMEOUT_EN
          tout_d  = '0;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.billete_ack) begin
          req_d        = 1'b0;
          n_d[sel_q]   = n_q[sel_q] - CNT_W'(1);
          cnt_d[sel_q] = cnt_q[sel_q] - CNT_W'(1);
          restante_d   = restante_q - DEN_TAB[sel_q];
          state_d      = ST_GAP;
        end
`ifdef ACK_TIMEOUT_EN
        else if (tout_q == TOUT_W'(TIMEOUT_CYC - 1)) begin
          req_d       = 1'b0;
          error_cod_d = ERR_TOUT;
          state_d     = ST_ERR;
        end else begin
          tout_d = tout_q + TOUT_W'(1);
        end
`endif
      end
      ST_GAP:  state_d = ST_DISP;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      restante_q  <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      n_q         <= '0;
      sel_q       <= 2'd0;
      req_q       <= 1'b0;
      error_cod_q <= ERR_NONE;
`ifdef ACK_TIMEOUT_EN
      tout_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      restante_q  <= restante_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      n_q         <= n_d;
      sel_q       <= sel_d;
      req_q       <= req_d;
      error_cod_q <= error_cod_d;
`ifdef ACK_TIMEOUT_EN
      tout_q      <= tout_d;
`endif
    end
  end

  assign bus.billete_req    = req_q;
  assign bus.billete_sel    = sel_q;
  assign bus.ocupado        = (state_q != ST_IDLE);
  assign bus.dispensa_ok    = (state_q == ST_DONE);
  assign bus.dispensa_error = (state_q == ST_ERR);
  assign bus.error_cod      = error_cod_q;
  assign bus.restante       = restante_q;
  assign bus.conteo         = cnt_q;
  assign bus.estado         = state_q;

endmodule

// File: tb/tb_secuenciador_billetes.sv
// Directed bench for secuenciador_billetes: a small dispenser model acks bills and
// records the cassette sequence, which each scenario checks against hand-derived values.
module tb_secuenciador_billetes;
  import secuenciador_billetes_pkg::*;

  localparam int MW = 32;
  localparam int CW = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  logic       saw_ok;
  logic       saw_err;
  int         first_req_cyc;
  int         min_gap;

  always #5 clk = ~clk;

  secuenciador_billetes_if #(.MONTO_W(MW), .CNT_W(CW)) bus ();

  secuenciador_billetes #(.MONTO_W(MW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [4*CW-1:0] pack_cnt(input int c0, input int c1, input int c2, input int c3);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input int c);
    for (int i = 0; i < 4; i++) begin
      bus.carga_stb = 1'b1;
      bus.carga_sel = 2'(i);
      bus.carga_cnt = CW'(c);
      tick();
    end
    bus.carga_stb = 1'b0;
  endtask

  // Returns in the first cycle after the strobe has been sampled.
  task automatic start(input logic [MW-1:0] m);
    bus.entregar_dinero = 1'b1;
    bus.monto           = m;
    tick();
    bus.entregar_dinero = 1'b0;
  endtask

  // Dispenser model: acks each request on its first cycle up to max_acks bills.
  task automatic dispense(input int max_acks, input int budget);
    int  gap;
    int  acks;
    logic done;
    got_q.delete();
    saw_ok = 1'b0; saw_err = 1'b0;
    first_req_cyc = -1; min_gap = 1000; gap = 0; acks = 0; done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      bus.billete_ack = 1'b0;
      if (bus.dispensa_ok)    saw_ok  = 1'b1;
      if (bus.dispensa_error) saw_err = 1'b1;
      if (saw_ok || saw_err) begin
        done = 1'b1;
        break;
      end
      if (bus.billete_req) begin
        if (first_req_cyc < 0) first_req_cyc = c + 1;
        else if (gap < min_gap) min_gap = gap;
        if (acks < max_acks) begin
          got_q.push_back(bus.billete_sel);
          bus.billete_ack = 1'b1;
          acks++;
        end
        gap = 0;
      end else begin
        gap++;
      end
      tick();
    end
    bus.billete_ack = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL dispense_budget: no ok/error pulse within %0d cycles, required completion", budget);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.billete_req, bus.ocupado, bus.dispensa_ok, bus.dispensa_error} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: req/ocup/ok/err=%b required 0000",
               {bus.billete_req, bus.ocupado, bus.dispensa_ok, bus.dispensa_error});
    end
    checks++;
    if (bus.conteo !== '0 || bus.restante !== '0 || bus.error_cod !== ERR_NONE) begin
      failures++;
      $display("FAIL reset_data: conteo=%h restante=%0d cod=%b required 0/0/00",
               bus.conteo, bus.restante, bus.error_cod);
    end
    checks++;
    if (bus.estado !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: estado=%0d required %0d", bus.estado, ST_IDLE);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_breakdown();
    load_all(5);
    start(32'd36000);
    dispense(10, 60);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b36000_count: bills=%0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [1:0] e;
      logic [1:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b36000_sel: sel=%0d required %0d", g, e);
      end
    end
    checks++;
    if (first_req_cyc != 6) begin
      failures++;
      $display("FAIL b36000_latency: first req cycle=%0d required 6", first_req_cyc);
    end
    checks++;
    if (saw_ok !== 1'b1 || saw_err !== 1'b0) begin
      failures++;
      $display("FAIL b36000_result: ok=%b err=%b required 1/0", saw_ok, saw_err);
    end
    checks++;
    if (bus.restante !== 32'd0 || bus.conteo !== pack_cnt(4, 4, 4, 4) || bus.error_cod !== ERR_NONE) begin
      failures++;
      $display("FAIL b36000_final: restante=%0d conteo=%h cod=%b required 0/%h/00",
               bus.restante, bus.conteo, bus.error_cod, pack_cnt(4, 4, 4, 4));
    end
    checks++;
    if (bus.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL b36000_idle: ocupado=%b required 0", bus.ocupado);
    end
  endtask

  task automatic test_back_to_back();
    start(32'd6000);
    dispense(10, 60);
    exp_q = '{2'd2, 2'd3};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: bills=%0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [1:0] e;
      logic [1:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b2b_sel: sel=%0d required %0d", g, e);
      end
    end
    checks++;
    if (saw_ok !== 1'b1 || bus.conteo !== pack_cnt(4, 4, 3, 3)) begin
      failures++;
      $display("FAIL b2b_final: ok=%b conteo=%h required 1/%h", saw_ok, bus.conteo, pack_cnt(4, 4, 3, 3));
    end
  endtask

  task automatic test_no_change();
    load_all(5);
    start(32'd3500);
    dispense(10, 60);
    checks++;
    if (got_q.size() != 0 || first_req_cyc != -1) begin
      failures++;
      $display("FAIL b3500_noreq: bills=%0d first_req=%0d required 0/-1", got_q.size(), first_req_cyc);
    end
    checks++;
    if (saw_err !== 1'b1 || saw_ok !== 1'b0 || bus.error_cod !== ERR_STOCK) begin
      failures++;
      $display("FAIL b3500_error: err=%b ok=%b cod=%b required 1/0/01", saw_err, saw_ok, bus.error_cod);
    end
    checks++;
    if (bus.conteo !== pack_cnt(5, 5, 5, 5) || bus.restante !== 32'd3500) begin
      failures++;
      $display("FAIL b3500_stock: conteo=%h restante=%0d required %h/3500",
               bus.conteo, bus.restante, pack_cnt(5, 5, 5, 5));
    end
  endtask

  task automatic test_empty_cassette();
    load_all(5);
    // Reload cassette 0 to empty in the same cycle as the start strobe.
    bus.carga_stb       = 1'b1;
    bus.carga_sel       = 2'd0;
    bus.carga_cnt       = '0;
    bus.entregar_dinero = 1'b1;
    bus.monto           = 32'd40000;
    tick();
    bus.carga_stb       = 1'b0;
    bus.entregar_dinero = 1'b0;
    dispense(10, 80);
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b40000_count: bills=%0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [1:0] e;
      logic [1:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b40000_sel: sel=%0d required %0d", g, e);
      end
    end
    checks++;
    if (min_gap < 1) begin
      failures++;
      $display("FAIL b40000_gap: min low cycles between req=%0d required >=1", min_gap);
    end
    checks++;
    if (saw_ok !== 1'b1 || bus.conteo !== pack_cnt(0, 1, 5, 5)) begin
      failures++;
      $display("FAIL b40000_final: ok=%b conteo=%h required 1/%h", saw_ok, bus.conteo, pack_cnt(0, 1, 5, 5));
    end
  endtask

  task automatic test_zero_amount();
    start(32'd0);
    dispense(10, 20);
    checks++;
    if (saw_err !== 1'b1 || bus.error_cod !== ERR_ZERO || got_q.size() != 0) begin
      failures++;
      $display("FAIL zero_amount: err=%b cod=%b bills=%0d required 1/11/0", saw_err, bus.error_cod, got_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    load_all(5);
    start(32'd36000);
    checks++;
    if (bus.ocupado !== 1'b1) begin
      failures++;
      $display("FAIL busy_ocupado: ocupado=%b required 1", bus.ocupado);
    end
    bus.entregar_dinero = 1'b1;
    bus.monto           = 32'd1000;
    bus.carga_stb       = 1'b1;
    bus.carga_sel       = 2'd0;
    bus.carga_cnt       = CW'(9);
    tick();
    bus.entregar_dinero = 1'b0;
    bus.carga_stb       = 1'b0;
    dispense(10, 60);
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL busy_bills: bills=%0d required 4", got_q.size());
    end
    checks++;
    if (saw_ok !== 1'b1 || bus.conteo !== pack_cnt(4, 4, 4, 4)) begin
      failures++;
      $display("FAIL busy_final: ok=%b conteo=%h required 1/%h", saw_ok, bus.conteo, pack_cnt(4, 4, 4, 4));
    end
  endtask

  task automatic test_reset_midway();
    int waited;
    load_all(5);
    start(32'd36000);
    waited = 0;
    while (bus.billete_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.billete_req !== 1'b1) begin
      failures++;
      $display("FAIL midreset_req: req=%b after %0d cycles required 1", bus.billete_req, waited);
    end
    bus.billete_ack = 1'b1;
    tick();
    bus.billete_ack = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.billete_req !== 1'b0 || bus.ocupado !== 1'b0 || bus.conteo !== '0 || bus.restante !== '0) begin
      failures++;
      $display("FAIL midreset_clear: req=%b ocup=%b conteo=%h restante=%0d required 0/0/0/0",
               bus.billete_req, bus.ocupado, bus.conteo, bus.restante);
    end
    reset = 1'b1;
    tick();
  endtask

`ifdef ACK_TIMEOUT_EN
  task automatic test_ack_timeout();
    load_all(5);
    start(32'd36000);
    dispense(1, 400);
    checks++;
    if (saw_err !== 1'b1 || bus.error_cod !== ERR_TOUT) begin
      failures++;
      $display("FAIL timeout_error: err=%b cod=%b required 1/10", saw_err, bus.error_cod);
    end
    checks++;
    if (bus.restante !== 32'd16000 || bus.conteo !== pack_cnt(4, 5, 5, 5) || bus.billete_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_final: restante=%0d conteo=%h req=%b required 16000/%h/0",
               bus.restante, bus.conteo, bus.billete_req, pack_cnt(4, 5, 5, 5));
    end
  endtask
`endif

  initial begin
    bus.entregar_dinero = 1'b0;
    bus.monto           = '0;
    bus.carga_stb       = 1'b0;
    bus.carga_sel       = 2'd0;
    bus.carga_cnt       = '0;
    bus.billete_ack     = 1'b0;
    test_reset();
    test_full_breakdown();
    test_back_to_back();
    test_no_change();
    test_empty_cassette();
    test_zero_amount();
    test_busy_ignore();
    test_reset_midway();
`ifdef ACK_TIMEOUT_EN
    test_ack_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
